// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus between instr_fetch_unit (master) and IMem (slave).
// IMemReq is held until the cycle IMemValid returns the word at IMemAddr.
interface instr_fetch_unit_if #(
    parameter int PCW = 8,
    parameter int IW  = 8
);
    logic           IMemReq;
    logic [PCW-1:0] IMemAddr;
    logic           IMemValid;
    logic [IW-1:0]  IMemData;

    modport master (
        output IMemReq, IMemAddr,
        input  IMemValid, IMemData
    );

    modport slave (
        input  IMemReq, IMemAddr,
        output IMemValid, IMemData
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC and IR, fetches over the IMem req/valid bus and
// applies controller decisions (LoadIR/IncPC/SelPC/LoadPC with Z/C) in EXEC.
// Optional macro FETCH_TIMEOUT_EN adds a FETCH watchdog and FetchTimeout output.
module instr_fetch_unit #(
    parameter int PCW     = 8,
    parameter int IW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              CLB,
    instr_fetch_unit_if.master imem,
    output logic [3:0]        Opcode,
    output logic [IW-5:0]     Operand,
    output logic              ExecValid,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              Z,
    input  logic              C,
    input  logic [PCW-1:0]    RegTarget,
    output logic [PCW-1:0]    PC,
    output logic              Halted,
    output logic              IllegalOp
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              FetchTimeout
`endif
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] FETCH  = 2'b01;
    localparam logic [1:0] EXEC   = 2'b10;
    localparam logic [1:0] HALTED = 2'b11;

    logic [1:0]     state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic           halted_q, halted_d;
    logic           illegal_q, illegal_d;
    logic           taken;
    logic [PCW-1:0] pc_inc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic           fetch_timeout_q, fetch_timeout_d;
    assign FetchTimeout = fetch_timeout_q;
`endif

    // Request is purely state-decoded so an async reset drops it in the same cycle.
    assign imem.IMemReq  = (state_q == FETCH);
    assign imem.IMemAddr = pc_q;
    assign ExecValid     = (state_q == EXEC);
    assign Opcode        = ir_q[IW-1:IW-4];
    assign Operand       = ir_q[IW-5:0];
    assign PC            = pc_q;
    assign Halted        = halted_q;
    assign IllegalOp     = illegal_q;
    assign pc_inc        = pc_q + PCW'(1);

    // Branch condition: Z for 0110/0111, C for 1000/1010, otherwise unconditional.
    always_comb begin
        taken = 1'b1;
        case (Opcode)
            4'b0110, 4'b0111: taken = Z;
            4'b1000, 4'b1010: taken = C;
            default:          taken = 1'b1;
        endcase
    end

    // Next-state, PC, IR and sticky-flag computation.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d       = '0;
        fetch_timeout_d = fetch_timeout_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem.IMemValid) begin
                    ir_d    = imem.IMemData;
                    state_d = EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                    fetch_timeout_d = 1'b1;
                    halted_d        = 1'b1;
                    state_d         = HALTED;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
`endif
            end
            EXEC: begin
                if (Opcode == 4'b1001 || Opcode == 4'b1110) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = HALTED;
                end else if (!LoadIR) begin
                    halted_d = 1'b1;
                    state_d  = HALTED;
                end else begin
                    state_d = FETCH;
                    if (LoadPC) begin
                        if (taken) pc_d = SelPC ? PCW'(Operand) : RegTarget;
                        else       pc_d = pc_inc;
                    end else if (IncPC) begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: ; // HALTED: only CLB leaves
        endcase
    end

    // State and datapath registers, async active-low clear.
    always_ff @(posedge Clk or negedge CLB) begin
        if (!CLB) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            fetch_timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
            fetch_timeout_q <= fetch_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: IMem responder with programmable latency, a tiny
// controller decode, and a scoreboard of expected fetch addresses.
module tb_instr_fetch_unit;
    logic       Clk = 0;
    logic       CLB = 0;
    logic [3:0] Opcode;
    logic [3:0] Operand;
    logic       ExecValid, LoadIR, IncPC, SelPC, LoadPC, Z, C;
    logic [7:0] RegTarget, PC;
    logic       Halted, IllegalOp;
`ifdef FETCH_TIMEOUT_EN
    logic       FetchTimeout;
`endif

    instr_fetch_unit_if #(.PCW(8), .IW(8)) mif ();

    instr_fetch_unit #(.PCW(8), .IW(8), .TIMEOUT(16)) dut (
        .Clk(Clk), .CLB(CLB), .imem(mif.master),
        .Opcode(Opcode), .Operand(Operand), .ExecValid(ExecValid),
        .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
        .Z(Z), .C(C), .RegTarget(RegTarget),
        .PC(PC), .Halted(Halted), .IllegalOp(IllegalOp)
`ifdef FETCH_TIMEOUT_EN
        , .FetchTimeout(FetchTimeout)
`endif
    );

    always #5 Clk = ~Clk;

    // minimal controller: 0xF is HALT, 6/7/8/A are jumps, everything else steps
    assign LoadIR = (Opcode != 4'hF);
    assign LoadPC = (Opcode inside {4'h6, 4'h7, 4'h8, 4'hA});
    assign IncPC  = 1'b1;

    logic [7:0] mem [256];
    int         lat = 0;
    int         n_chk = 0, n_err = 0;
    int         sbq [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // IMem model: answers after lat wait cycles; each accepted fetch is scored
    initial begin : responder
        int wcnt;
        int exp;
        wcnt = 0;
        mif.IMemValid = 0;
        mif.IMemData  = '0;
        forever begin
            @(negedge Clk);
            if (CLB && mif.IMemReq) begin
                if (wcnt >= lat) begin
                    mif.IMemValid = 1;
                    mif.IMemData  = mem[mif.IMemAddr];
                    wcnt = 0;
                    exp = (sbq.size() != 0) ? sbq.pop_front() : 32'hDEAD;
                    chk("fetch_addr", 32'(mif.IMemAddr), exp);
                end else begin
                    mif.IMemValid = 0;
                    wcnt++;
                end
            end else begin
                mif.IMemValid = 0;
                wcnt = 0;
            end
        end
    end

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic do_reset();
        CLB = 0;
        sbq.delete();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        CLB = 1;
    endtask

    task automatic wait_halt(input int max);
        int i;
        i = 0;
        while (!Halted && i < max) begin @(posedge Clk); #1; i++; end
        chk("halt_reached", 32'(Halted), 1);
    endtask

    task automatic wait_sb_empty(input int max);
        int i;
        i = 0;
        while (sbq.size() != 0 && i < max) begin @(posedge Clk); #1; i++; end
        chk("sb_drained", sbq.size(), 0);
    endtask

    task automatic count_req(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin @(posedge Clk); #1; if (mif.IMemReq) n++; end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int n;
        Z = 0; C = 0; SelPC = 1; RegTarget = 8'h00;

        // reset state
        fill_halt();
        CLB = 0;
        #12;
        chk("rst_req", 32'(mif.IMemReq), 0);
        chk("rst_exec", 32'(ExecValid), 0);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_halted", 32'(Halted), 0);
        chk("rst_illegal", 32'(IllegalOp), 0);
        chk("rst_opcode", 32'(Opcode), 0);

        // 1: zero-wait NOP, NOP, HALT
        fill_halt(); mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hF0; lat = 0;
        do_reset(); sbq = '{0, 1, 2};
        wait_halt(40);
        chk("t1_pc", 32'(PC), 2);
        chk("t1_illegal", 32'(IllegalOp), 0);
        chk("t1_sb", sbq.size(), 0);
        count_req(6, n);
        chk("t1_no_req", n, 0);
        chk("t1_halted_sticky", 32'(Halted), 1);

        // 2: wait-stated fetch of 0xD5
        fill_halt(); mem[0] = 8'hD5; lat = 3;
        do_reset(); sbq = '{0, 1};
        n = 0;
        for (int i = 0; i < 40 && !ExecValid; i++) begin
            @(posedge Clk); #1;
            if (mif.IMemReq) n++;
        end
        chk("t2_in_exec", 32'(ExecValid), 1);
        chk("t2_req_cycles", n, 4);
        chk("t2_opcode", 32'(Opcode), 4'hD);
        chk("t2_operand", 32'(Operand), 5);
        @(posedge Clk); #1;
        chk("t2_pc", 32'(PC), 1);
        wait_halt(40);

        // 3: conditional immediate jump 0x7A at PC=3, Z taken and not taken
        for (int zz = 1; zz >= 0; zz--) begin
            fill_halt(); mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h7A;
            lat = 0; Z = zz[0]; SelPC = 1;
            do_reset();
            if (zz == 1) sbq = '{0, 1, 2, 3, 8'h0A}; else sbq = '{0, 1, 2, 3, 4};
            wait_halt(60);
            chk(zz == 1 ? "t3_pc_taken" : "t3_pc_nottaken", 32'(PC), zz == 1 ? 32'h0A : 32'h04);
            chk("t3_sb", sbq.size(), 0);
        end
        Z = 0;

        // 4: register jump on C to 0xF0, then NOPs wrap 0xFF -> 0x00
        fill_halt(); mem[0] = 8'h80;
        for (int i = 8'hF0; i <= 8'hFF; i++) mem[i] = 8'h00;
        C = 1; SelPC = 0; RegTarget = 8'hF0; lat = 0;
        do_reset();
        sbq.push_back(0);
        for (int i = 8'hF0; i <= 8'hFF; i++) sbq.push_back(i);
        sbq.push_back(0);
        wait_sb_empty(100);
        chk("t4_pc_wrap", 32'(PC), 0);
        chk("t4_not_halted", 32'(Halted), 0);
        C = 0; SelPC = 1; RegTarget = 8'h00;

        // 5: undefined opcode 0x9 at PC=1
        fill_halt(); mem[0] = 8'h00; mem[1] = 8'h93; lat = 0;
        do_reset(); sbq = '{0, 1};
        wait_halt(40);
        chk("t5_illegal", 32'(IllegalOp), 1);
        chk("t5_pc", 32'(PC), 1);
        count_req(8, n);
        chk("t5_no_req", n, 0);
        chk("t5_ir_held", 32'(Opcode), 9);
        CLB = 0; #1;
        chk("t5_clr_illegal", 32'(IllegalOp), 0);
        chk("t5_clr_halted", 32'(Halted), 0);

        // 6: memory never answers
        fill_halt(); lat = 100000;
        do_reset();
        n = 0;
        for (int i = 0; i < 10 && !mif.IMemReq; i++) begin @(posedge Clk); #1; end
        chk("t6_in_fetch", 32'(mif.IMemReq), 1);
`ifdef FETCH_TIMEOUT_EN
        repeat (15) @(posedge Clk);
        #1;
        chk("t6_no_tmo_yet", 32'(FetchTimeout), 0);
        chk("t6_still_fetch", 32'(mif.IMemReq), 1);
        @(posedge Clk); #1;
        chk("t6_timeout", 32'(FetchTimeout), 1);
        chk("t6_halted", 32'(Halted), 1);
        chk("t6_req_off", 32'(mif.IMemReq), 0);
        chk("t6_pc_hold", 32'(PC), 0);
        CLB = 0; #1;
        chk("t6_clr_tmo", 32'(FetchTimeout), 0);
        chk("t6_clr_halted", 32'(Halted), 0);
`else
        repeat (40) @(posedge Clk);
        #1;
        chk("t6_waits", 32'(mif.IMemReq), 1);
        chk("t6_not_halted", 32'(Halted), 0);
`endif

        // CLB pulse mid-FETCH with PC=1
        fill_halt(); mem[0] = 8'h00; lat = 0;
        do_reset(); sbq = '{0};
        for (int i = 0; i < 20 && PC != 8'h01; i++) begin @(posedge Clk); #1; end
        lat = 100000;
        repeat (2) @(posedge Clk);
        #1;
        chk("rp_fetching_pc1", 32'({mif.IMemReq, mif.IMemAddr}), 32'h101);
        CLB = 0; #1;
        chk("rp_req_drop", 32'(mif.IMemReq), 0);
        chk("rp_pc", 32'(PC), 0);
        chk("rp_halted", 32'(Halted), 0);
        chk("rp_illegal", 32'(IllegalOp), 0);
`ifdef FETCH_TIMEOUT_EN
        chk("rp_tmo", 32'(FetchTimeout), 0);
`endif
        repeat (3) @(posedge Clk);
        #1;
        chk("rp_held_in_reset", 32'(mif.IMemReq), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
